avalon_frame_regs: RTL

Parametrised Avalon-MM register file that feeds the game renderer through a wide exported conduit. CPU writes land in a shadow bank; the live bank driving the conduit is updated only at a frame boundary, so sprite position, state and flag changes never tear mid-frame. The block sits between the NIOS Avalon fabric and the drawing/sprite logic. It adds per-byte enables, registered reads, a commit handshake, a frame counter and a commit-done pulse.

---
 rtl/game_regs_pkg.sv | 30 +++
 rtl/frame_edge_detect.sv | 21 ++
 rtl/avalon_frame_regs.sv | 131 +++++++++++++
 3 files changed

// File: rtl/game_regs_pkg.sv
// Shared constants and helpers for the Avalon frame register file:
// control-space offsets, control/status bit positions and byte-lane merge.
package game_regs_pkg;

  // Word offsets inside the control space (address MSB = 1)
  localparam int CTRL_OFS = 0;
  localparam int STAT_OFS = 1;
  localparam int FCNT_OFS = 2;

  // CONTROL register bits
  localparam int CTRL_COMMIT_REQ_BIT  = 0;
  localparam int CTRL_AUTO_COMMIT_BIT = 1;

  // STATUS register bits
  localparam int STAT_PENDING_BIT = 0;

  // Replace each byte lane of old_val with the matching lane of new_val
  // when its enable is set; lanes without an enable keep their old contents.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector for the vsync level. The previous sample is held in
// a register; the edge output is high in the cycle where FRAME_SYNC=1 and
// the stored previous value is 0, so a held-high sync yields one edge only.
module frame_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic FRAME_SYNC,
  output logic FRAME_EDGE
);

  logic sync_prev_q;

  // Remember last cycle's sync level; cleared by reset
  always_ff @(posedge CLK) begin
    if (!RESET) sync_prev_q <= 1'b0;
    else        sync_prev_q <= FRAME_SYNC;
  end

  assign FRAME_EDGE = FRAME_SYNC && !sync_prev_q;

endmodule

// File: rtl/avalon_frame_regs.sv
// Avalon-MM double-buffered register file for the game renderer.
// CPU writes go to a shadow bank; the live bank that drives EXPORT_DATA is
// copied from the shadow bank in a single cycle at a frame edge, when a
// commit is pending or auto-commit is enabled, so the renderer never sees a
// half-updated frame.
//
// Bus handshake: a transfer is accepted when AVL_CS is high together with
// AVL_WRITE or AVL_READ; there is no wait-request, every accepted transfer
// completes in that cycle. Read data is registered and appears exactly one
// cycle after the accepted read, and is 0 in any cycle not following a read.
module avalon_frame_regs
  import game_regs_pkg::*;
#(
  parameter int NUM_REGS          = 64,
  parameter int ADDR_W            = $clog2(NUM_REGS) + 1,
  parameter int RESET_FRAME_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic                  AVL_CS,
  input  logic [3:0]            AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]     AVL_ADDR,
  input  logic [31:0]           AVL_WRITEDATA,
  output logic [31:0]           AVL_READDATA,
  input  logic                  FRAME_SYNC,
  output logic                  COMMIT_DONE,
  output logic [NUM_REGS*32-1:0] EXPORT_DATA
);

  localparam int IDX_W = ADDR_W - 1;

  logic [31:0] shadow_q [NUM_REGS];
  logic [31:0] live_q   [NUM_REGS];

  logic                         auto_commit_q;
  logic                         pending_q;
  logic                         commit_done_q;
  logic [RESET_FRAME_CNT_W-1:0] frame_cnt_q;
  logic [31:0]                  rd_mux;

  logic             frame_edge;
  logic             wr_en;
  logic             rd_en;
  logic             ctrl_space;
  logic [IDX_W-1:0] idx;
  logic             ctrl_wr;
  logic             commit_req_wr;
  logic             commit;

  frame_edge_detect u_edge (
    .CLK        (CLK),
    .RESET      (RESET),
    .FRAME_SYNC (FRAME_SYNC),
    .FRAME_EDGE (frame_edge)
  );

  assign wr_en      = AVL_WRITE && AVL_CS;
  assign rd_en      = AVL_READ && AVL_CS;
  assign ctrl_space = AVL_ADDR[ADDR_W-1];
  assign idx        = AVL_ADDR[IDX_W-1:0];

  // Control bits live in byte lane 0, so they only change when lane 0 is enabled
  assign ctrl_wr       = wr_en && ctrl_space && (idx == IDX_W'(CTRL_OFS)) && AVL_BYTE_EN[0];
  assign commit_req_wr = ctrl_wr && AVL_WRITEDATA[CTRL_COMMIT_REQ_BIT];
  assign commit        = frame_edge && (pending_q || auto_commit_q);

  // Shadow bank: byte-lane merged CPU writes
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (wr_en && !ctrl_space) begin
      shadow_q[idx] <= byte_merge(shadow_q[idx], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

  // Live bank: whole-bank copy of the pre-write shadow contents on commit
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) live_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) live_q[i] <= shadow_q[i];
    end
  end

  // Control state: auto-commit, pending request, done pulse, frame counter.
  // A request written in the commit cycle survives to the next frame.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      auto_commit_q <= 1'b0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (ctrl_wr) auto_commit_q <= AVL_WRITEDATA[CTRL_AUTO_COMMIT_BIT];
      if (commit_req_wr) pending_q <= 1'b1;
      else if (commit)   pending_q <= 1'b0;
      commit_done_q <= commit;
      if (frame_edge) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // Read mux over shadow bank and control space
  always_comb begin
    rd_mux = '0;
    if (!ctrl_space) begin
      rd_mux = shadow_q[idx];
    end else if (idx == IDX_W'(CTRL_OFS)) begin
      rd_mux[CTRL_AUTO_COMMIT_BIT] = auto_commit_q;
    end else if (idx == IDX_W'(STAT_OFS)) begin
      rd_mux[STAT_PENDING_BIT] = pending_q;
    end else if (idx == IDX_W'(FCNT_OFS)) begin
      rd_mux = 32'(frame_cnt_q);
    end
  end

  // Registered read data, zero when no read was accepted last cycle
  always_ff @(posedge CLK) begin
    if (!RESET)     AVL_READDATA <= '0;
    else if (rd_en) AVL_READDATA <= rd_mux;
    else            AVL_READDATA <= '0;
  end

  assign COMMIT_DONE = commit_done_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign EXPORT_DATA[32*g +: 32] = live_q[g];
  end

endmodule
